// File: rtl/pcpi_initiator.sv
// PCPI initiator: accepts one command at a time, presents it on the PCPI
// request port, and returns exactly one response. The response is a
// coprocessor result, an unclaimed timeout or a watchdog abort.
module pcpi_initiator #(
   parameter int TIMEOUT_CYCLES  = 16,
   parameter int WATCHDOG_CYCLES = 1024
) (
   input  logic        clkIn,
   input  logic        rstLowIn,
   // command side
   input  logic        cmdValidIn,
   output logic        cmdReadyOut,
   input  logic [31:0] cmdInstIn,
   input  logic [31:0] cmdRs1In,
   input  logic [31:0] cmdRs2In,
   // PCPI side
   output logic        pcipValidOut,
   output logic [31:0] pcipInstOut,
   output logic [31:0] pcipRs1Out,
   output logic [31:0] pcipRs2Out,
   input  logic        pcipWaitIn,
   input  logic        pcipReadyIn,
   input  logic        pcipWrIn,
   input  logic [31:0] pcipRdIn,
   // response side
   output logic        rspValidOut,
   input  logic        rspReadyIn,
   output logic [31:0] rspDataOut,
   output logic        rspWrOut,
   output logic [1:0]  rspStatusOut
);

   localparam int MAX_CYC = (TIMEOUT_CYCLES > WATCHDOG_CYCLES) ? TIMEOUT_CYCLES : WATCHDOG_CYCLES;
   localparam int CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] WD_LAST = CW'(WATCHDOG_CYCLES - 1);

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_UNCLAIM = 2'b01;
   localparam logic [1:0] ST_ABORT   = 2'b10;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   inst_q, inst_d;
   logic [31:0]   rs1_q, rs1_d;
   logic [31:0]   rs2_q, rs2_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          rwr_q, rwr_d;
   logic [1:0]    rstat_q, rstat_d;

   // State and datapath registers; reset clears everything asynchronously.
   always_ff @(posedge clkIn or negedge rstLowIn) begin
      if (!rstLowIn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         inst_q  <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rdata_q <= '0;
         rwr_q   <= 1'b0;
         rstat_q <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         inst_q  <= inst_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rdata_q <= rdata_d;
         rwr_q   <= rwr_d;
         rstat_q <= rstat_d;
      end
   end

   // Next state: ready beats wait, wait beats timeout; the counter saturates
   // at its expiry value so it never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      inst_d  = inst_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      rdata_d = rdata_q;
      rwr_d   = rwr_q;
      rstat_d = rstat_q;
      unique case (state_q)
         IDLE: begin
            if (cmdValidIn) begin
               state_d = ISSUE;
               cnt_d   = '0;
               inst_d  = cmdInstIn;
               rs1_d   = cmdRs1In;
               rs2_d   = cmdRs2In;
            end
         end
         ISSUE: begin
            if (pcipReadyIn) begin
               state_d = RESP;
               rdata_d = pcipRdIn;
               rwr_d   = pcipWrIn;
               rstat_d = ST_OK;
            end else if (pcipWaitIn) begin
               state_d = WAIT;
               cnt_d   = '0;
            end else if (cnt_q == TO_LAST) begin
               state_d = RESP;
               rdata_d = '0;
               rwr_d   = 1'b0;
               rstat_d = ST_UNCLAIM;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT: begin
            if (pcipReadyIn) begin
               state_d = RESP;
               rdata_d = pcipRdIn;
               rwr_d   = pcipWrIn;
               rstat_d = ST_OK;
            end else if (cnt_q == WD_LAST) begin
               state_d = RESP;
               rdata_d = '0;
               rwr_d   = 1'b0;
               rstat_d = ST_ABORT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (rspReadyIn) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from state or driven straight from registers.
   always_comb begin
      cmdReadyOut  = (state_q == IDLE);
      pcipValidOut = (state_q == ISSUE) || (state_q == WAIT);
      pcipInstOut  = inst_q;
      pcipRs1Out   = rs1_q;
      pcipRs2Out   = rs2_q;
      rspValidOut  = (state_q == RESP);
      rspDataOut   = rdata_q;
      rspWrOut     = rwr_q;
      rspStatusOut = rstat_q;
   end

endmodule

// File: tb/tb_pcpi_initiator.sv
// Randomized bench for pcpi_initiator. The coprocessor is scripted per
// transaction: the first wait edge, how long wait is held, and the ready edge.
// The expected outcome is worked out arithmetically from those edges.
module tb_pcpi_initiator;

   localparam int TO    = 16;
   localparam int WD    = 8;
   localparam int LIMIT = TO + WD + 8;

   logic        clkIn = 1'b0;
   logic        rstLowIn = 1'b0;
   logic        cmdValidIn = 1'b0;
   logic        cmdReadyOut;
   logic [31:0] cmdInstIn = '0, cmdRs1In = '0, cmdRs2In = '0;
   logic        pcipValidOut;
   logic [31:0] pcipInstOut, pcipRs1Out, pcipRs2Out;
   logic        pcipWaitIn = 1'b0, pcipReadyIn = 1'b0, pcipWrIn = 1'b0;
   logic [31:0] pcipRdIn = '0;
   logic        rspValidOut;
   logic        rspReadyIn = 1'b0;
   logic [31:0] rspDataOut;
   logic        rspWrOut;
   logic [1:0]  rspStatusOut;

   int total = 0;
   int bad   = 0;

   pcpi_initiator #(.TIMEOUT_CYCLES(TO), .WATCHDOG_CYCLES(WD)) dut (
      .clkIn(clkIn), .rstLowIn(rstLowIn),
      .cmdValidIn(cmdValidIn), .cmdReadyOut(cmdReadyOut),
      .cmdInstIn(cmdInstIn), .cmdRs1In(cmdRs1In), .cmdRs2In(cmdRs2In),
      .pcipValidOut(pcipValidOut), .pcipInstOut(pcipInstOut),
      .pcipRs1Out(pcipRs1Out), .pcipRs2Out(pcipRs2Out),
      .pcipWaitIn(pcipWaitIn), .pcipReadyIn(pcipReadyIn),
      .pcipWrIn(pcipWrIn), .pcipRdIn(pcipRdIn),
      .rspValidOut(rspValidOut), .rspReadyIn(rspReadyIn),
      .rspDataOut(rspDataOut), .rspWrOut(rspWrOut), .rspStatusOut(rspStatusOut)
   );

   always #5 clkIn = ~clkIn;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One full transaction. wt: edge index (1 = first edge after issue) where
   // wait first rises, 0 = never; wait stays high for wl+1 edges. rt: edge
   // index of a single-cycle ready, 0 = never. bp: cycles of response stall.
   task automatic run_txn(input logic [31:0] inst, input logic [31:0] rs1,
                          input logic [31:0] rs2, input int wt, input int wl,
                          input int rt, input logic [31:0] rd, input logic wr,
                          input int bp);
      int          dl, tend, t;
      logic [1:0]  est;
      logic [31:0] edata;
      logic        ewr;
      bit          live;
      // reference: a claim inside the timeout window arms the watchdog
      if (wt >= 1 && wt <= TO) begin dl = wt + WD; est = 2'b10; end
      else begin dl = TO; est = 2'b01; end
      if (rt >= 1 && rt <= dl) begin
         tend = rt; est = 2'b00; edata = rd; ewr = wr;
      end else begin
         tend = dl; edata = '0; ewr = 1'b0;
      end

      @(negedge clkIn);
      chk("cmd_ready_idle", 32'(cmdReadyOut), 32'd1);
      cmdValidIn = 1'b1; cmdInstIn = inst; cmdRs1In = rs1; cmdRs2In = rs2;
      @(posedge clkIn);
      @(negedge clkIn);
      cmdValidIn = 1'b0; cmdInstIn = $urandom; cmdRs1In = $urandom; cmdRs2In = $urandom;
      chk("pcip_valid_issue", 32'(pcipValidOut), 32'd1);
      chk("pcip_inst", pcipInstOut, inst);
      chk("pcip_rs1", pcipRs1Out, rs1);
      chk("pcip_rs2", pcipRs2Out, rs2);

      t = 0; live = 1'b1;
      while (live) begin
         t++;
         pcipWaitIn  = (wt >= 1) && (t >= wt) && (t <= wt + wl);
         pcipReadyIn = (t == rt);
         pcipRdIn    = (t == rt) ? rd : 32'($urandom);
         pcipWrIn    = (t == rt) ? wr : 1'($urandom);
         @(posedge clkIn);
         @(negedge clkIn);
         if (!pcipValidOut || t >= LIMIT) live = 1'b0;
         else if (pcipInstOut !== inst || pcipRs1Out !== rs1 || pcipRs2Out !== rs2)
            chk("pcip_hold", pcipInstOut ^ pcipRs1Out ^ pcipRs2Out, inst ^ rs1 ^ rs2);
      end
      pcipWaitIn = 1'b0; pcipReadyIn = 1'b0;
      pcipRdIn = $urandom; pcipWrIn = 1'($urandom);
      chk("valid_cycles", 32'(t), 32'(tend));
      chk("rsp_valid", 32'(rspValidOut), 32'd1);
      chk("rsp_data", rspDataOut, edata);
      chk("rsp_wr", 32'(rspWrOut), 32'(ewr));
      chk("rsp_status", 32'(rspStatusOut), 32'(est));

      // stall the response while offering another command that must not be taken
      for (int i = 0; i < bp; i++) begin
         cmdValidIn = 1'b1;
         @(posedge clkIn);
         @(negedge clkIn);
         chk("bp_valid", 32'(rspValidOut), 32'd1);
         chk("bp_data", rspDataOut, edata);
         chk("bp_status", 32'(rspStatusOut), 32'(est));
         chk("bp_cmd_ready", 32'(cmdReadyOut), 32'd0);
         chk("bp_no_issue", 32'(pcipValidOut), 32'd0);
      end
      cmdValidIn = 1'b0;
      rspReadyIn = 1'b1;
      @(posedge clkIn);
      @(negedge clkIn);
      rspReadyIn = 1'b0;
      chk("rsp_done", 32'(rspValidOut), 32'd0);
      chk("back_idle", 32'(cmdReadyOut), 32'd1);
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_cmd_ready", 32'(cmdReadyOut), 32'd1);
      chk("rst_pcip_valid", 32'(pcipValidOut), 32'd0);
      chk("rst_pcip_inst", pcipInstOut, 32'd0);
      chk("rst_rsp_valid", 32'(rspValidOut), 32'd0);
      chk("rst_rsp_status", 32'(rspStatusOut), 32'd0);
      @(negedge clkIn);
      rstLowIn = 1'b1;

      // fmul.s: wait after one cycle, ready three cycles later
      run_txn(32'h10C58553, 32'h40000000, 32'h40400000, 1, 2, 4, 32'h40C00000, 1'b1, 0);
      // minimum latency: ready on the first edge
      run_txn(32'h0000000B, 32'h1, 32'h2, 0, 0, 1, 32'hCAFEF00D, 1'b1, 0);
      // silent coprocessor
      run_txn(32'h00000000, 32'h0, 32'h0, 0, 0, 0, 32'h0, 1'b0, 0);
      // watchdog with wait held the whole time
      run_txn(32'h0000002B, 32'h5, 32'h6, 1, LIMIT, 0, 32'h0, 1'b0, 0);
      // ready in the last timeout cycle
      run_txn(32'h0000004B, 32'h7, 32'h8, 0, 0, TO, 32'h12345678, 1'b1, 0);
      // ready in the last watchdog cycle, wait dropped early
      run_txn(32'h0000006B, 32'h9, 32'hA, 3, 0, 3 + WD, 32'h0BADBEEF, 1'b0, 0);
      // ready and wait together
      run_txn(32'h0000008B, 32'hB, 32'hC, 2, 4, 2, 32'h55AA55AA, 1'b1, 0);
      // back-pressure
      run_txn(32'h000000AB, 32'hD, 32'hE, 0, 0, 2, 32'hFEEDFACE, 1'b1, 5);

      // random mix
      for (int n = 0; n < 40; n++) begin
         run_txn($urandom, $urandom, $urandom,
                 int'($urandom_range(0, TO + 1)), int'($urandom_range(0, 12)),
                 int'($urandom_range(0, TO + WD + 2)), $urandom, 1'($urandom),
                 int'($urandom_range(0, 3)));
      end

      // reset while in WAIT: outputs clear at once and no response follows
      @(negedge clkIn);
      cmdValidIn = 1'b1; cmdInstIn = 32'h13579BDF; cmdRs1In = 32'h1; cmdRs2In = 32'h2;
      @(posedge clkIn);
      @(negedge clkIn);
      cmdValidIn = 1'b0;
      pcipWaitIn = 1'b1;
      repeat (3) @(negedge clkIn);
      chk("pre_rst_valid", 32'(pcipValidOut), 32'd1);
      #2 rstLowIn = 1'b0;
      #1;
      chk("arst_pcip_valid", 32'(pcipValidOut), 32'd0);
      chk("arst_pcip_inst", pcipInstOut, 32'd0);
      chk("arst_pcip_rs1", pcipRs1Out, 32'd0);
      chk("arst_cmd_ready", 32'(cmdReadyOut), 32'd1);
      chk("arst_rsp_valid", 32'(rspValidOut), 32'd0);
      @(negedge clkIn);
      rstLowIn = 1'b1;
      pcipWaitIn = 1'b0;
      for (int i = 0; i < WD + 4; i++) begin
         @(negedge clkIn);
         if (rspValidOut !== 1'b0 || pcipValidOut !== 1'b0)
            chk("post_rst_quiet", 32'({rspValidOut, pcipValidOut}), 32'd0);
      end
      chk("post_rst_idle", 32'(cmdReadyOut), 32'd1);
      run_txn(32'h2468ACE0, 32'h3, 32'h4, 1, 1, 3, 32'h87654321, 1'b1, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
